// File: rtl/spi_flash_target.sv
// -----------------------------------------------------------------------------
// spi_flash_target
//
// SPI serial-flash target front end (mode 0, MSB first). The SPI pins are
// oversampled by the system clock through 2-flop synchronizers, and all
// protocol handling runs in the single 'clock' domain. The clock must run at
// least 8x the SCL rate.
//
// Supported commands:
//   8'h9F  JEDEC ID   -> MANUFACTURER_ID, MEMORY_TYPE, MEMORY_CAP, then 8'h00
//   8'h05  status     -> statusIn, re-sampled for every byte
//   8'h03  read       -> 24-bit address on IO0, data on IO1
//   8'hEB  quad read  -> quad address, mode byte, 4 dummies, quad data
//   8'hFF  exit continuous-read mode
//
// Optional feature macro: SPI_TARGET_QUAD_EN
//   Defined   : 8'hEB, quad data, continuous-read mode and 8'hFF are active.
//   Undefined : 8'hEB and 8'hFF are ignored, contReadMode is tied 0 and only
//               IO1 can ever be driven.
//
// Ports:
//   clock        system clock
//   nReset       asynchronous active-low reset
//   spiScl       SPI clock from the initiator
//   spiNCs       chip select, active low
//   spiIoIn      IO3..IO0 pad inputs (IO0 = SI)
//   spiIoOut     IO3..IO0 output values
//   spiIoDriven  per-pad drive enables, 1 = driven
//   memAddress   byte address to the backing store
//   memRead      one-cycle read strobe to the backing store
//   memData      store byte, valid one clock after memRead
//   statusIn     value returned by the status command
//   contReadMode continuous-read mode flag
// -----------------------------------------------------------------------------
module spi_flash_target #(
  parameter logic [7:0] MANUFACTURER_ID = 8'hEF,
  parameter logic [7:0] MEMORY_TYPE     = 8'h40,
  parameter logic [7:0] MEMORY_CAP      = 8'h18
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        spiScl,
  input  logic        spiNCs,
  input  logic [3:0]  spiIoIn,
  output logic [3:0]  spiIoOut,
  output logic [3:0]  spiIoDriven,
  output logic [23:0] memAddress,
  output logic        memRead,
  input  logic [7:0]  memData,
  input  logic [7:0]  statusIn,
  output logic        contReadMode
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  // Where the bytes of the DATA phase come from.
  typedef enum logic [1:0] {
    SRC_JEDEC,
    SRC_STATUS,
    SRC_MEM
  } src_t;

  // Synchronizers and edge-detect history.
  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] ncs_sync_q, ncs_sync_d;
  logic [3:0] io_meta_q, io_meta_d;
  logic [3:0] io_sync_q, io_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       ncs_prev_q, ncs_prev_d;

  // Protocol state.
  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic        quad_q, quad_d;
  logic        cont_q, cont_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  out_q, out_d;
  logic [23:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        fill_q, fill_d;
  logic [1:0]  jedec_q, jedec_d;

  logic        scl_s, ncs_s;
  logic [3:0]  io_s;
  logic        scl_rise, scl_fall, ncs_rise, ncs_fall;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_nxt;
  logic        last_unit;

  // Synchronizer next values. Chip select resets to the deselected level so
  // leaving reset never looks like a frame start.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], spiScl};
    ncs_sync_d = {ncs_sync_q[0], spiNCs};
    io_meta_d  = spiIoIn;
    io_sync_d  = io_meta_q;
    scl_prev_d = scl_sync_q[1];
    ncs_prev_d = ncs_sync_q[1];
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      scl_sync_q <= 2'b00;
      ncs_sync_q <= 2'b11;
      io_meta_q  <= 4'h0;
      io_sync_q  <= 4'h0;
      scl_prev_q <= 1'b0;
      ncs_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      ncs_sync_q <= ncs_sync_d;
      io_meta_q  <= io_meta_d;
      io_sync_q  <= io_sync_d;
      scl_prev_q <= scl_prev_d;
      ncs_prev_q <= ncs_prev_d;
    end
  end

  assign scl_s = scl_sync_q[1];
  assign ncs_s = ncs_sync_q[1];
  assign io_s  = io_sync_q;

  // SCL edges only count while the target is selected.
  assign scl_rise = scl_s & ~scl_prev_q & ~ncs_s;
  assign scl_fall = ~scl_s & scl_prev_q & ~ncs_s;
  assign ncs_fall = ~ncs_s & ncs_prev_q;
  assign ncs_rise = ncs_s & ~ncs_prev_q;

  assign cmd_byte = {shift_q[6:0], io_s[0]};

  // Next-state and datapath logic. A store byte requested by memRead is
  // captured the clock after the strobe; the byte currently on the pad lives
  // in out_q, so reloading tx_q during the last bit is safe.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    quad_d    = quad_q;
    cont_d    = cont_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    out_d     = out_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    fill_d    = rd_q;
    jedec_d   = jedec_q;
    addr_nxt  = 24'h0;
    last_unit = 1'b0;

    if (fill_q) begin
      tx_d = memData;
    end

    case (state_q)
      IDLE: begin
        out_d   = 4'h0;
        cnt_d   = 5'd0;
        shift_d = 23'h0;
        if (ncs_fall) begin
          jedec_d = 2'd0;
          if (cont_q) begin
            state_d = ADDR;
            quad_d  = 1'b1;
            src_d   = SRC_MEM;
          end else begin
            state_d = CMD;
            quad_d  = 1'b0;
          end
        end
      end

      CMD: begin
        if (scl_rise) begin
          shift_d = {shift_q[21:0], io_s[0]};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = 5'd0;
            shift_d = 23'h0;
            case (cmd_byte)
              8'h9F: begin
                state_d = DATA;
                src_d   = SRC_JEDEC;
                tx_d    = MANUFACTURER_ID;
                jedec_d = 2'd1;
              end
              8'h05: begin
                state_d = DATA;
                src_d   = SRC_STATUS;
                tx_d    = statusIn;
              end
              8'h03: begin
                state_d = ADDR;
                src_d   = SRC_MEM;
                quad_d  = 1'b0;
              end
`ifdef SPI_TARGET_QUAD_EN
              8'hEB: begin
                state_d = ADDR;
                src_d   = SRC_MEM;
                quad_d  = 1'b1;
              end
              8'hFF: begin
                cont_d  = 1'b0;
                state_d = IGNORE;
              end
`endif
              default: state_d = IGNORE;
            endcase
          end
        end
      end

      ADDR: begin
        if (scl_rise) begin
          if (quad_q) begin
            addr_nxt  = {shift_q[19:0], io_s};
            last_unit = (cnt_q == 5'd5);
          end else begin
            addr_nxt  = {shift_q, io_s[0]};
            last_unit = (cnt_q == 5'd23);
          end
          shift_d = addr_nxt[22:0];
          cnt_d   = cnt_q + 5'd1;
          if (last_unit) begin
            cnt_d   = 5'd0;
            shift_d = 23'h0;
            addr_d  = addr_nxt;
            rd_d    = 1'b1;
            state_d = quad_q ? MODE : DATA;
          end
        end
      end

      // Mode byte arrives as two nibbles; M[5:4] = 2'b10 requests
      // continuous-read for the following frames.
      MODE: begin
        if (scl_rise) begin
          shift_d = {shift_q[18:0], io_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            cont_d  = (shift_q[1:0] == 2'b10);
            cnt_d   = 5'd0;
            shift_d = 23'h0;
            state_d = DUMMY;
          end
        end
      end

      DUMMY: begin
        if (scl_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd3) begin
            cnt_d   = 5'd0;
            state_d = DATA;
          end
        end
      end

      // Output bits/nibbles change on the falling edge. The last unit of a
      // byte also fetches the next byte.
      DATA: begin
        if (scl_fall) begin
          if (quad_q) begin
            out_d     = cnt_q[0] ? tx_q[3:0] : tx_q[7:4];
            last_unit = cnt_q[0];
          end else begin
            out_d     = {2'b00, tx_q[3'd7 - cnt_q[2:0]], 1'b0};
            last_unit = (cnt_q[2:0] == 3'd7);
          end
          cnt_d = last_unit ? 5'd0 : cnt_q + 5'd1;
          if (last_unit) begin
            case (src_q)
              SRC_JEDEC: begin
                case (jedec_q)
                  2'd1:    tx_d = MEMORY_TYPE;
                  2'd2:    tx_d = MEMORY_CAP;
                  default: tx_d = 8'h00;
                endcase
                jedec_d = (jedec_q == 2'd3) ? 2'd3 : jedec_q + 2'd1;
              end
              SRC_STATUS: tx_d = statusIn;
              default: begin
                rd_d   = 1'b1;
                addr_d = addr_q + 24'd1;
              end
            endcase
          end
        end
      end

      IGNORE: begin
        out_d = 4'h0;
      end

      default: state_d = IDLE;
    endcase

    // Deselect wins over everything and drops any partial byte.
    if (ncs_rise) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      shift_d = 23'h0;
      out_d   = 4'h0;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      src_q   <= SRC_JEDEC;
      quad_q  <= 1'b0;
      cont_q  <= 1'b0;
      cnt_q   <= 5'd0;
      shift_q <= 23'h0;
      tx_q    <= 8'h00;
      out_q   <= 4'h0;
      addr_q  <= 24'h0;
      rd_q    <= 1'b0;
      fill_q  <= 1'b0;
      jedec_q <= 2'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      quad_q  <= quad_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      jedec_q <= jedec_d;
    end
  end

  // Drive enables decode straight from the state flop so reset releases the
  // pads immediately.
`ifdef SPI_TARGET_QUAD_EN
  assign spiIoDriven  = (state_q == DATA) ? (quad_q ? 4'hF : 4'h2) : 4'h0;
  assign contReadMode = cont_q;
`else
  assign spiIoDriven  = {2'b00, (state_q == DATA), 1'b0};
  assign contReadMode = 1'b0;
`endif

  assign spiIoOut   = out_q;
  assign memAddress = addr_q;
  assign memRead    = rd_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_target
//
// Self-checking bench for spi_flash_target. Single-mode frames are described
// by a table of vectors; abort, reset and quad/continuous-read sequences are
// written out by hand. The backing store returns the low byte of the address.
// -----------------------------------------------------------------------------
module tb_spi_flash_target;

  logic        clock = 1'b0;
  logic        nReset;
  logic        spiScl;
  logic        spiNCs;
  logic [3:0]  spiIoIn;
  logic [3:0]  spiIoOut;
  logic [3:0]  spiIoDriven;
  logic [23:0] memAddress;
  logic        memRead;
  logic [7:0]  memData = 8'h00;
  logic [7:0]  statusIn;
  logic        contReadMode;

  int tests_run    = 0;
  int tests_failed = 0;
  int rd_count     = 0;

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  status;
    int          nbytes;
    logic [31:0] exp_bytes;
    int          exp_reads;
    logic [3:0]  exp_drv;
    bit          chk_addr;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  spi_flash_target dut (
    .clock        (clock),
    .nReset       (nReset),
    .spiScl       (spiScl),
    .spiNCs       (spiNCs),
    .spiIoIn      (spiIoIn),
    .spiIoOut     (spiIoOut),
    .spiIoDriven  (spiIoDriven),
    .memAddress   (memAddress),
    .memRead      (memRead),
    .memData      (memData),
    .statusIn     (statusIn),
    .contReadMode (contReadMode)
  );

  always #5 clock = ~clock;

  // Backing store: byte = address LSB, one clock latency; also counts strobes.
  always @(posedge clock) begin
    if (memRead) begin
      memData  <= memAddress[7:0];
      rd_count <= rd_count + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One SCL period: pads are sampled just before the rising edge.
  task automatic xfer(input logic [3:0] io, output logic [3:0] pad,
                      output logic [3:0] drv);
    spiIoIn = io;
    tick(8);
    pad    = spiIoOut;
    drv    = spiIoDriven;
    spiScl = 1'b1;
    tick(8);
    spiScl = 1'b0;
  endtask

  task automatic frame_start();
    spiNCs = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    tick(4);
    spiNCs = 1'b1;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] pad, drv;
    for (int i = 7; i >= 0; i--) xfer({3'b000, b[i]}, pad, drv);
  endtask

  task automatic read_single(output logic [7:0] b, inout logic [3:0] d_or,
                             inout logic [3:0] d_and);
    logic [3:0] pad, drv;
    for (int i = 7; i >= 0; i--) begin
      xfer(4'h0, pad, drv);
      b[i]  = pad[1];
      d_or  = d_or | drv;
      d_and = d_and & drv;
    end
  endtask

  task automatic read_quad(output logic [7:0] b, inout logic [3:0] d_or,
                           inout logic [3:0] d_and);
    logic [3:0] pad, drv;
    xfer(4'h0, pad, drv);
    b[7:4] = pad;
    d_or = d_or | drv; d_and = d_and & drv;
    xfer(4'h0, pad, drv);
    b[3:0] = pad;
    d_or = d_or | drv; d_and = d_and & drv;
  endtask

  task automatic send_nibbles(input logic [23:0] v, input int n);
    logic [3:0] pad, drv;
    for (int i = n - 1; i >= 0; i--) xfer(v[4*i +: 4], pad, drv);
  endtask

  // Runs one single-mode frame from the vector table and checks it.
  task automatic applyStimulus(input vec_t v);
    int         base;
    logic [7:0] b;
    logic [3:0] pad, drv;
    logic [3:0] d_or, d_and;
    d_or     = 4'h0;
    d_and    = 4'hF;
    statusIn = v.status;
    base     = rd_count;
    frame_start();
    send_byte(v.cmd);
    if (v.cmd == 8'h03) begin
      for (int i = 23; i >= 0; i--) xfer({3'b000, v.addr[i]}, pad, drv);
    end
    for (int k = 0; k < v.nbytes; k++) begin
      read_single(b, d_or, d_and);
      checkOutput($sformatf("%s_byte%0d", v.name, k), {24'h0, b},
                  {24'h0, v.exp_bytes[31 - 8*k -: 8]});
    end
    frame_end();
    checkOutput({v.name, "_drv_or"},  {28'h0, d_or},  {28'h0, v.exp_drv});
    checkOutput({v.name, "_drv_and"}, {28'h0, d_and}, {28'h0, v.exp_drv});
    checkOutput({v.name, "_reads"}, rd_count - base, v.exp_reads);
    if (v.chk_addr) checkOutput({v.name, "_addr"}, {8'h0, memAddress}, {8'h0, v.exp_addr});
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] pad, drv, d_or, d_and;
    int         base;

    vecs[0] = '{"jedec",  8'h9F, 24'h000000, 8'h00, 4, 32'hEF401800, 0, 4'h2, 1'b0, 24'h0};
    vecs[1] = '{"status", 8'h05, 24'h000000, 8'hA5, 2, 32'hA5A50000, 0, 4'h2, 1'b0, 24'h0};
    vecs[2] = '{"read10", 8'h03, 24'h000010, 8'h00, 3, 32'h10111200, 4, 4'h2, 1'b1, 24'h000013};
    vecs[3] = '{"readFE", 8'h03, 24'h0000FE, 8'h00, 3, 32'hFEFF0000, 4, 4'h2, 1'b1, 24'h000101};
    vecs[4] = '{"wrap",   8'h03, 24'hFFFFFF, 8'h00, 3, 32'hFF000100, 4, 4'h2, 1'b1, 24'h000002};
    vecs[5] = '{"ignore", 8'hAB, 24'h000000, 8'h00, 2, 32'h00000000, 0, 4'h0, 1'b0, 24'h0};

    nReset   = 1'b0;
    spiScl   = 1'b0;
    spiNCs   = 1'b1;
    spiIoIn  = 4'h0;
    statusIn = 8'h00;
    tick(3);
    checkOutput("rst_drv",  {28'h0, spiIoDriven}, 32'h0);
    checkOutput("rst_out",  {28'h0, spiIoOut}, 32'h0);
    checkOutput("rst_addr", {8'h0, memAddress}, 32'h0);
    checkOutput("rst_rd",   {31'h0, memRead}, 32'h0);
    checkOutput("rst_cont", {31'h0, contReadMode}, 32'h0);
    nReset = 1'b1;
    tick(4);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Deselect after 5 of the 8 bits of 8'h03, then a clean JEDEC read.
    frame_start();
    for (int i = 0; i < 5; i++) xfer(4'h0, pad, drv);
    spiNCs = 1'b1;
    tick(6);
    checkOutput("abort_cmd_drv", {28'h0, spiIoDriven}, 32'h0);
    tick(4);
    applyStimulus(vecs[0]);

    // Deselect in the middle of a read data byte.
    base = rd_count;
    frame_start();
    send_byte(8'h03);
    for (int i = 23; i >= 0; i--) xfer({3'b000, 1'b0}, pad, drv);
    for (int i = 0; i < 4; i++) xfer(4'h0, pad, drv);
    checkOutput("abort_data_drv_before", {28'h0, spiIoDriven}, 32'h2);
    spiNCs = 1'b1;
    tick(5);
    checkOutput("abort_data_drv_after", {28'h0, spiIoDriven}, 32'h0);
    checkOutput("abort_data_reads", rd_count - base, 1);
    tick(4);

    // Reset in the middle of a single-mode data byte.
    frame_start();
    send_byte(8'h03);
    for (int i = 23; i >= 0; i--) xfer({3'b000, 1'b1}, pad, drv);
    for (int i = 0; i < 3; i++) xfer(4'h0, pad, drv);
    nReset = 1'b0;
    #1;
    checkOutput("rst_mid_drv",  {28'h0, spiIoDriven}, 32'h0);
    checkOutput("rst_mid_out",  {28'h0, spiIoOut}, 32'h0);
    checkOutput("rst_mid_addr", {8'h0, memAddress}, 32'h0);
    tick(2);
    spiNCs = 1'b1;
    nReset = 1'b1;
    tick(4);

`ifdef SPI_TARGET_QUAD_EN
    // Quad read at the top of the address space with continuous-read mode.
    base = rd_count; d_or = 4'h0; d_and = 4'hF;
    frame_start();
    send_byte(8'hEB);
    send_nibbles(24'hFFFFFF, 6);
    send_nibbles(24'h000020, 2);
    send_nibbles(24'h000000, 4);
    read_quad(b, d_or, d_and);
    checkOutput("quad_b0", {24'h0, b}, 32'hFF);
    read_quad(b, d_or, d_and);
    checkOutput("quad_b1", {24'h0, b}, 32'h00);
    frame_end();
    checkOutput("quad_drv_or",  {28'h0, d_or},  32'hF);
    checkOutput("quad_drv_and", {28'h0, d_and}, 32'hF);
    checkOutput("quad_reads", rd_count - base, 3);
    checkOutput("quad_cont", {31'h0, contReadMode}, 32'h1);

    // Continuous-read frame: address straight away, mode 8'h00 exits.
    d_or = 4'h0; d_and = 4'hF;
    frame_start();
    send_nibbles(24'h000020, 6);
    send_nibbles(24'h000000, 2);
    send_nibbles(24'h000000, 4);
    read_quad(b, d_or, d_and);
    checkOutput("cont_b0", {24'h0, b}, 32'h20);
    read_quad(b, d_or, d_and);
    checkOutput("cont_b1", {24'h0, b}, 32'h21);
    frame_end();
    checkOutput("cont_drv_and", {28'h0, d_and}, 32'hF);
    checkOutput("cont_exit", {31'h0, contReadMode}, 32'h0);

    // Reset during quad data.
    frame_start();
    send_byte(8'hEB);
    send_nibbles(24'h000040, 6);
    send_nibbles(24'h000020, 2);
    send_nibbles(24'h000000, 4);
    xfer(4'h0, pad, drv);
    checkOutput("qrst_nib", {28'h0, pad}, 32'h4);
    checkOutput("qrst_cont_before", {31'h0, contReadMode}, 32'h1);
    nReset = 1'b0;
    #1;
    checkOutput("qrst_drv",  {28'h0, spiIoDriven}, 32'h0);
    checkOutput("qrst_cont", {31'h0, contReadMode}, 32'h0);
    tick(2);
    spiNCs = 1'b1;
    nReset = 1'b1;
    tick(4);
`else
    // Without quad support 8'hEB is ignored and nothing is driven.
    base = rd_count; d_or = 4'h0;
    frame_start();
    send_byte(8'hEB);
    for (int i = 0; i < 16; i++) begin
      xfer(4'hF, pad, drv);
      d_or = d_or | drv;
    end
    frame_end();
    checkOutput("eb_ignore_drv",   {28'h0, d_or}, 32'h0);
    checkOutput("eb_ignore_reads", rd_count - base, 0);
    checkOutput("eb_ignore_cont",  {31'h0, contReadMode}, 32'h0);
`endif

    // A final JEDEC frame after all the corner cases.
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Whole-run time limit.
  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
